// File: rtl/spi_sram_responder.sv
// SPI mode-0 responder emulating a 23LC-style serial SRAM (READ 0x03 /
// WRITE 0x02, 16-bit address, sequential mode). Pins are oversampled with
// clk and bytes are served from a synchronous backing-memory port.
//
// state   | meaning
// IDLE    | waiting for a synchronised CS fall
// CMD     | shifting in the 8-bit instruction
// ADDR    | shifting in the 16-bit address
// RD_DATA | driving MISO, prefetching the next byte at each byte boundary
// WR_DATA | assembling bytes from MOSI, one mem_wr per completed byte
// IGNORE  | unknown instruction, silent until CS rises
module spi_sram_responder #(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d, settle_q, settle_d;
  logic                   sck_prev_q, sck_prev_d, armed_q, armed_d;
  logic                   cs_s, sck_s, mosi_s, sck_rise, sck_fall;

  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [14:0]            sh_q, sh_d;
  logic [15:0]            sh_next;
  logic [7:0]             tx_q, tx_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   is_rd_q, is_rd_d;
  logic                   mem_rd_q, mem_rd_d, rd_wait_q, rd_wait_d;
  logic                   mem_wr_q, mem_wr_d, inc_q, inc_d;
  logic [7:0]             wdata_q, wdata_d;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  // Synchroniser shift, SCK edge history, and arming. After reset the
  // responder only arms once the chain holds real pin samples showing CS
  // high, so a CS that is still low from an interrupted transaction is not
  // mistaken for a fresh fall.
  always_comb begin
    cs_sync_d   = (cs_sync_q << 1) | SYNC_STAGES'(spi_cs_n);
    sck_sync_d  = (sck_sync_q << 1) | SYNC_STAGES'(spi_sck);
    mosi_sync_d = (mosi_sync_q << 1) | SYNC_STAGES'(spi_mosi);
    settle_d    = (settle_q << 1) | SYNC_STAGES'(1);
    sck_prev_d  = sck_s;
    armed_d     = armed_q | ((&settle_q) & cs_s);
  end

  // Front-end registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      settle_q    <= '0;
      sck_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      settle_q    <= settle_d;
      sck_prev_q  <= sck_prev_d;
      armed_q     <= armed_d;
    end
  end

  // Next-state and datapath. In RD_DATA the bit counter counts rises; the
  // fall after the 8th rise is the byte boundary that triggers the prefetch,
  // and the fetched byte's MSB appears on MISO as soon as it is latched.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    tx_d      = rd_wait_q ? mem_rdata : tx_q;
    addr_d    = inc_q ? addr_q + ADDR_W'(1) : addr_q;
    is_rd_d   = is_rd_q;
    mem_rd_d  = 1'b0;
    rd_wait_d = mem_rd_q;
    mem_wr_d  = 1'b0;
    inc_d     = 1'b0;
    wdata_d   = wdata_q;
    sh_next   = {sh_q, mosi_s};
    unique case (state_q)
      IDLE: begin
        if (armed_q && !cs_s) begin
          state_d   = CMD;
          bit_cnt_d = '0;
        end
      end
      CMD: begin
        if (cs_s) begin
          state_d = IDLE;
        end else if (sck_rise) begin
          sh_d      = sh_next[14:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (sh_next[7:0] == 8'h03) begin
              state_d = ADDR;
              is_rd_d = 1'b1;
            end else if (sh_next[7:0] == 8'h02) begin
              state_d = ADDR;
              is_rd_d = 1'b0;
            end else begin
              state_d = IGNORE;
            end
          end
        end
      end
      ADDR: begin
        if (cs_s) begin
          state_d = IDLE;
        end else if (sck_rise) begin
          sh_d      = sh_next[14:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = '0;
            addr_d    = sh_next[ADDR_W-1:0];
            tx_d      = '0;
            if (is_rd_q) begin
              mem_rd_d = 1'b1;
              state_d  = RD_DATA;
            end else begin
              state_d  = WR_DATA;
            end
          end
        end
      end
      RD_DATA: begin
        if (cs_s) begin
          state_d = IDLE;
        end else if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (sck_fall) begin
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            addr_d    = addr_q + ADDR_W'(1);
            mem_rd_d  = 1'b1;
            tx_d      = '0;
          end else if (bit_cnt_q != 4'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      WR_DATA: begin
        // A rise coinciding with CS going high still completes its byte.
        if (sck_rise) begin
          sh_d      = sh_next[14:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            mem_wr_d  = 1'b1;
            wdata_d   = sh_next[7:0];
            inc_d     = 1'b1;
          end
        end
        if (cs_s) begin
          state_d = IDLE;
        end
      end
      IGNORE: begin
        if (cs_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      is_rd_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      rd_wait_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      inc_q     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      is_rd_q   <= is_rd_d;
      mem_rd_q  <= mem_rd_d;
      rd_wait_q <= rd_wait_d;
      mem_wr_q  <= mem_wr_d;
      inc_q     <= inc_d;
      wdata_q   <= wdata_d;
    end
  end

  assign spi_miso_oe = (state_q == RD_DATA);
  assign spi_miso    = (state_q == RD_DATA) & tx_q[7];
  assign mem_addr    = addr_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_wdata   = wdata_q;
  assign busy        = armed_q & ~cs_s;

endmodule
